// File: rtl/pe_seq_controller.sv
// rtl/pe_seq_controller.sv - fold/level sequencing controller for a residual binarized PE
// Outputs are registered from the next-state values, so each one reflects the state it is in.
module pe_seq_controller #(
  parameter int NUM_LEVELS = 2,
  parameter int LVL_W      = 1,
  parameter int PCNT_LAT   = 2,
  parameter int FOLD_W     = 8,
  parameter int OUT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [FOLD_W-1:0] num_folds,
  input  logic [OUT_W-1:0]  num_outputs,
  input  logic              rd_valid,
  input  logic              bin_done,
  output logic              rd_req,
  output logic              pcnt_en,
  output logic              acc_en,
  output logic              acc_first,
  output logic [LVL_W-1:0]  level_sel,
  output logic              bin_start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_PCNT  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_ACC   = 3'd4;
  localparam logic [2:0] S_BIN   = 3'd5;
  localparam logic [2:0] S_BWAIT = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam int WAIT_W = (PCNT_LAT > 1) ? $clog2(PCNT_LAT) : 1;
  localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(NUM_LEVELS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PCNT_LAT - 1);

  logic [2:0]        state, state_n;
  logic [FOLD_W-1:0] fold_cnt, fold_n, nf_q, nf_n;
  logic [OUT_W-1:0]  out_cnt, out_n, no_q, no_n;
  logic [LVL_W-1:0]  lvl_cnt, lvl_n;
  logic [WAIT_W-1:0] wait_cnt, wait_n;
  logic              rej_q, rej_n;
  logic [FOLD_W-1:0] fold_last;
  logic [OUT_W-1:0]  out_last;

  // Compared only once the counts are known to be non-zero, so no wrap.
  assign fold_last = nf_q - FOLD_W'(1);
  assign out_last  = no_q - OUT_W'(1);

  always_comb begin
    state_n = state;
    fold_n  = fold_cnt;
    out_n   = out_cnt;
    lvl_n   = lvl_cnt;
    wait_n  = wait_cnt;
    nf_n    = nf_q;
    no_n    = no_q;
    rej_n   = rej_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          nf_n = num_folds;
          no_n = num_outputs;
          if ((num_folds == '0) || (num_outputs == '0)) begin
            rej_n   = 1'b1;
            state_n = S_DONE;
          end else begin
            rej_n   = 1'b0;
            fold_n  = '0;
            out_n   = '0;
            lvl_n   = '0;
            state_n = S_READ;
          end
        end
      end
      S_READ: begin
        if (rd_valid && rd_req) begin
          lvl_n   = '0;
          state_n = S_PCNT;
        end
      end
      S_PCNT: begin
        wait_n  = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_n = S_ACC;
        end else begin
          wait_n = wait_cnt + WAIT_W'(1);
        end
      end
      S_ACC: begin
        if (lvl_cnt < LVL_LAST) begin
          lvl_n   = lvl_cnt + LVL_W'(1);
          state_n = S_PCNT;
        end else if (fold_cnt < fold_last) begin
          fold_n  = fold_cnt + FOLD_W'(1);
          state_n = S_READ;
        end else begin
          fold_n  = '0;
          state_n = S_BIN;
        end
      end
      S_BIN: state_n = S_BWAIT;
      S_BWAIT: begin
        if (bin_done) begin
          if (out_cnt < out_last) begin
            out_n   = out_cnt + OUT_W'(1);
            state_n = S_READ;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      state_n = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fold_cnt  <= '0;
      out_cnt   <= '0;
      lvl_cnt   <= '0;
      wait_cnt  <= '0;
      nf_q      <= '0;
      no_q      <= '0;
      rej_q     <= 1'b0;
      rd_req    <= 1'b0;
      pcnt_en   <= 1'b0;
      acc_en    <= 1'b0;
      acc_first <= 1'b0;
      level_sel <= '0;
      bin_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      fold_cnt  <= fold_n;
      out_cnt   <= out_n;
      lvl_cnt   <= lvl_n;
      wait_cnt  <= wait_n;
      nf_q      <= nf_n;
      no_q      <= no_n;
      rej_q     <= rej_n;
      rd_req    <= (state_n == S_READ);
      pcnt_en   <= (state_n == S_PCNT);
      acc_en    <= (state_n == S_ACC);
      acc_first <= (state_n == S_ACC) && (fold_n == '0);
      level_sel <= ((state_n == S_PCNT) || (state_n == S_WAIT) || (state_n == S_ACC)) ? lvl_n : '0;
      bin_start <= (state_n == S_BIN);
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
      err       <= (state_n == S_DONE) && rej_n;
    end
  end

endmodule
